loopback_filter: RTL

//  Byte-stream processing stage between the usb_cdc OUT bulk stream and its IN bulk stream.

---
 rtl/loopback_filter.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/loopback_filter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : loopback_filter
// Purpose  : Byte-stream stage placed between the usb_cdc OUT bulk stream and
//            its IN bulk stream.
//            - Received bytes are buffered in a small FIFO.
//            - Lower-case ASCII letters are optionally mapped to upper case
//              as they are written.
//            - A LF (0x0A) is optionally inserted after every CR (0x0D) that
//              leaves the output register.
//            Runs in the usb_cdc application clock domain.
// Ports    : clk_i       application clock
//            rstn_i      asynchronous reset, active low
//            rx_data_i   byte from usb_cdc out_data_o
//            rx_valid_i  from usb_cdc out_valid_o
//            rx_ready_o  to usb_cdc out_ready_i (registered)
//            tx_data_o   byte to usb_cdc in_data_i (registered)
//            tx_valid_o  to usb_cdc in_valid_i (registered)
//            tx_ready_i  from usb_cdc in_ready_o
//            level_o     bytes held in the FIFO, output register excluded
// Revision : 1.0 - initial release
// ============================================================================
module loopback_filter #(
   parameter int DEPTH     = 16,  // FIFO depth in bytes, power of 2, >= 2
   parameter int UPPERCASE = 1,   // 1: map 'a'..'z' to 'A'..'Z' on write
   parameter int CRLF      = 1    // 1: emit 0x0A after each transferred 0x0D
) (
   input  logic                       clk_i,
   input  logic                       rstn_i,
   input  logic [7:0]                 rx_data_i,
   input  logic                       rx_valid_i,
   output logic                       rx_ready_o,
   output logic [7:0]                 tx_data_o,
   output logic                       tx_valid_o,
   input  logic                       tx_ready_i,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int       AW      = $clog2(DEPTH);
   localparam int       LW      = AW + 1;
   localparam logic     CRLF_EN = (CRLF != 0);
   localparam logic [7:0] CR_BYTE = 8'h0D;
   localparam logic [7:0] LF_BYTE = 8'h0A;

   // Output FSM: IDLE = output register empty, DATA = FIFO byte presented,
   // LF = inserted line feed presented.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_DATA = 2'd1,
      S_LF   = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [LW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]     rd_ptr_q, rd_ptr_d;
   logic              rx_ready_q, rx_ready_d;
   logic [7:0]        tx_data_q, tx_data_d;
   logic              tx_valid_q, tx_valid_d;
   logic [7:0]        mem_q [DEPTH];

   logic [7:0]        wr_byte;
   logic [7:0]        head_byte;
   logic [LW-1:0]     level;
   logic [LW-1:0]     level_next;
   logic              fifo_empty;
   logic              push;
   logic              pop;
   logic              tx_xfer;

   // -------------------------------------------------------------------------
   // Write-side byte mapping
   // -------------------------------------------------------------------------
   if (UPPERCASE != 0) begin : g_upper
      always_comb begin
         wr_byte = rx_data_i;
         if (rx_data_i >= 8'h61 && rx_data_i <= 8'h7A) begin
            wr_byte = rx_data_i - 8'h20;
         end
      end
   end else begin : g_pass
      assign wr_byte = rx_data_i;
   end

   // -------------------------------------------------------------------------
   // FIFO bookkeeping
   // -------------------------------------------------------------------------
   // Pointers carry one extra bit so that full (difference == DEPTH) and
   // empty (difference == 0) are distinguishable.
   assign level      = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (level == '0);
   assign head_byte  = mem_q[rd_ptr_q[AW-1:0]];

   // rx_ready_q is only ever 1 while the FIFO has room, so a push can never
   // overflow; writes offered while it is 0 are simply not taken.
   assign push    = rx_valid_i && rx_ready_q;
   assign tx_xfer = tx_valid_q && tx_ready_i;

   assign wr_ptr_d   = wr_ptr_q + LW'(push);
   assign rd_ptr_d   = rd_ptr_q + LW'(pop);
   assign level_next = level + LW'(push) - LW'(pop);

   // Ready reflects the occupancy after this edge, so a pop on the same edge
   // that would otherwise leave the FIFO full re-opens the input at once.
   assign rx_ready_d = (level_next < LW'(DEPTH));

   // Storage is not reset: resetting the pointers discards its contents.
   // The head is read from the registered array, so a byte written on an
   // edge can only be popped on a later edge (no bypass path).
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= wr_byte;
      end
   end

   // -------------------------------------------------------------------------
   // Output FSM, next state and registered outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q;
      pop        = 1'b0;

      case (state_q)
         S_IDLE: begin
            tx_valid_d = 1'b0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               tx_data_d  = head_byte;
               tx_valid_d = 1'b1;
               state_d    = S_DATA;
            end
         end

         S_DATA: begin
            if (tx_xfer) begin
               if (CRLF_EN && (tx_data_q == CR_BYTE)) begin
                  // The FIFO head stays put until the inserted LF is taken.
                  tx_data_d = LF_BYTE;
                  state_d   = S_LF;
               end else if (!fifo_empty) begin
                  pop       = 1'b1;
                  tx_data_d = head_byte;
               end else begin
                  tx_valid_d = 1'b0;
                  state_d    = S_IDLE;
               end
            end
         end

         S_LF: begin
            if (tx_xfer) begin
               if (!fifo_empty) begin
                  pop       = 1'b1;
                  tx_data_d = head_byte;
                  state_d   = S_DATA;
               end else begin
                  tx_valid_d = 1'b0;
                  state_d    = S_IDLE;
               end
            end
         end

         default: begin
            tx_valid_d = 1'b0;
            state_d    = S_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rx_ready_q <= 1'b0;
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rx_ready_q <= rx_ready_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
      end
   end

   assign rx_ready_o = rx_ready_q;
   assign tx_data_o  = tx_data_q;
   assign tx_valid_o = tx_valid_q;
   assign level_o    = level;

endmodule
`default_nettype wire
